// File: rtl/stage_ctrl_seq.sv
// Four-phase pipeline stage controller with capture/resolve phase select, bounded retry and sticky fault.
// Build option: define STAGE_CTRL_ERRCNT_EN to include the saturating resolved-error counter.
module stage_ctrl_seq #(
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       l_req,
   output logic       l_ack,
   output logic       r_req,
   input  logic       r_ack,
   input  logic       re_ack,
   input  logic [1:0] err,
   output logic       go_ml,
   output logic       go_lm,
   output logic       clk_en,
   output logic       fault,
   output logic [7:0] err_count
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_EVAL    = 3'd2,
      ST_RESOLVE = 3'd3,
      ST_SEND    = 3'd4,
      ST_RELEASE = 3'd5,
      ST_FAULT   = 3'd6
   } state_t;

   localparam logic [4:0] MAX_RETRY_W = MAX_RETRY[4:0];

   state_t     state_r, state_s;
   logic [4:0] retry_r, retry_s;
   logic       l_ack_r, l_ack_s;
   logic       r_req_r, r_req_s;
   logic       clk_en_r, clk_en_s;
   logic       go_lm_r, go_lm_s;
   logic       go_ml_r;
   logic       fault_r, fault_s;
   logic       resolved_s;

   // Next-state, retry bookkeeping and next values of every registered output.
   always_comb begin
      state_s    = state_r;
      retry_s    = retry_r;
      resolved_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (l_req && !r_ack) begin
               state_s = ST_CAPTURE;
               retry_s = 5'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CAPTURE: state_s = ST_CAPTURE == state_r ? ST_EVAL : ST_IDLE;
         ST_EVAL: begin
            case (err)
               2'b00:   state_s = ST_SEND;
               2'b11:   state_s = ST_FAULT;
               default: begin
                  state_s = ST_RESOLVE;
                  retry_s = retry_r + 5'd1;
               end
            endcase
         end
         // retry_r runs one ahead of the failed-attempt count, so equality marks the last allowed failure
         ST_RESOLVE: begin
            if (err == 2'b11) begin
               state_s = ST_FAULT;
            end else if (re_ack) begin
               if (err == 2'b00) begin
                  state_s    = ST_SEND;
                  resolved_s = 1'b1;
               end else if (retry_r >= MAX_RETRY_W) begin
                  state_s = ST_FAULT;
               end else begin
                  retry_s = retry_r + 5'd1;
               end
            end else begin
               state_s = ST_RESOLVE;
            end
         end
         ST_SEND: begin
            if (r_ack) begin
               state_s = ST_RELEASE;
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_RELEASE: begin
            if (!r_ack && !l_ack_r) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RELEASE;
            end
         end
         ST_FAULT: state_s = ST_FAULT;
         default:  state_s = ST_IDLE;
      endcase

      clk_en_s = ((state_r == ST_IDLE) && (state_s == ST_CAPTURE)) || resolved_s;
      r_req_s  = (state_s == ST_SEND);
      go_lm_s  = (state_s == ST_RESOLVE);
      fault_s  = fault_r || (state_s == ST_FAULT);
      l_ack_s  = (state_r == ST_CAPTURE) || (l_ack_r && l_req);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         retry_r  <= 5'd0;
         l_ack_r  <= 1'b0;
         r_req_r  <= 1'b0;
         clk_en_r <= 1'b0;
         go_lm_r  <= 1'b0;
         go_ml_r  <= 1'b1;
         fault_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         retry_r  <= retry_s;
         l_ack_r  <= l_ack_s;
         r_req_r  <= r_req_s;
         clk_en_r <= clk_en_s;
         go_lm_r  <= go_lm_s;
         go_ml_r  <= ~go_lm_s;
         fault_r  <= fault_s;
      end
   end

`ifdef STAGE_CTRL_ERRCNT_EN
   logic [7:0] err_count_r;

   // Saturating count of errors resolved successfully.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count_r <= 8'd0;
      end else if (resolved_s && (err_count_r != 8'hFF)) begin
         err_count_r <= err_count_r + 8'd1;
      end else begin
         err_count_r <= err_count_r;
      end
   end

   assign err_count = err_count_r;
`else
   assign err_count = 8'd0;
`endif

   assign l_ack  = l_ack_r;
   assign r_req  = r_req_r;
   assign clk_en = clk_en_r;
   assign go_lm  = go_lm_r;
   assign go_ml  = go_ml_r;
   assign fault  = fault_r;

endmodule

// File: tb/tb_stage_ctrl_seq.sv
// Self-checking bench for stage_ctrl_seq: directed and randomized tokens scored against a token-level outcome model.
// Expects err_count activity only when STAGE_CTRL_ERRCNT_EN is defined.
module tb_stage_ctrl_seq;

   localparam int MAXR = 3;
`ifdef STAGE_CTRL_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       l_req = 1'b0;
   logic       r_ack = 1'b0;
   logic       re_ack = 1'b0;
   logic [1:0] err = 2'b00;
   logic       l_ack, r_req, go_ml, go_lm, clk_en, fault;
   logic [7:0] err_count;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int cyc = 0;
   int pulses, lm_cyc, req_cyc, viol, first_pulse, lack_rise;
   int exp_cnt = 0;
   logic prev_clk_en = 1'b0;
   logic prev_l_ack  = 1'b0;

   stage_ctrl_seq #(.MAX_RETRY(MAXR)) dut (
      .clk(clk), .rst(rst), .l_req(l_req), .l_ack(l_ack), .r_req(r_req), .r_ack(r_ack),
      .re_ack(re_ack), .err(err), .go_ml(go_ml), .go_lm(go_lm), .clk_en(clk_en),
      .fault(fault), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; sample just after the edge and accumulate per-token observations.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (clk_en && prev_clk_en) viol++;
      if (go_ml !== ~go_lm) viol++;
      if (clk_en) begin
         pulses++;
         if (first_pulse < 0) first_pulse = cyc;
      end
      if (l_ack && !prev_l_ack && lack_rise < 0) lack_rise = cyc;
      if (go_lm) lm_cyc++;
      if (r_req) req_cyc++;
      prev_clk_en = clk_en;
      prev_l_ack  = l_ack;
   endtask

   task automatic clear_stats();
      pulses = 0; lm_cyc = 0; req_cyc = 0; viol = 0; first_pulse = -1; lack_rise = -1;
   endtask

   task automatic check_reset_outs(input string tag);
      check(tag, {18'd0, l_ack, r_req, clk_en, go_ml, go_lm, fault, err_count},
            {18'd0, 6'b000100, 8'd0});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outs("reset_async");
      l_req = 1'b0; r_ack = 1'b0; re_ack = 1'b0; err = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_cnt = 0; prev_clk_en = 1'b0; prev_l_ack = 1'b0;
   endtask

   // Plays upstream, resolver and downstream for one token and scores the outcome.
   task automatic token(input logic [1:0] eval_err, input int n_fail, input logic [1:0] fail_code,
                        input int gap, input bit abort);
      int  k, d, rdel, guard, start_cyc, exp_pulses, exp_lm;
      bit  done, saw_req, exp_fault;
      if (eval_err == 2'b00) begin
         exp_fault = 1'b0; exp_pulses = 1; exp_lm = 0;
      end else if (eval_err == 2'b11) begin
         exp_fault = 1'b1; exp_pulses = 1; exp_lm = 0;
      end else if (n_fail > 0 && fail_code == 2'b11) begin
         exp_fault = 1'b1; exp_pulses = 1; exp_lm = 1 + gap;
      end else if (n_fail >= MAXR) begin
         exp_fault = 1'b1; exp_pulses = 1; exp_lm = gap + MAXR;
      end else begin
         exp_fault = 1'b0; exp_pulses = 2; exp_lm = 1 + gap + n_fail;
      end
      if (!exp_fault && eval_err != 2'b00 && CNT_EN && exp_cnt < 255) exp_cnt++;

      clear_stats();
      k = 0; d = int'($urandom_range(0, 3)); rdel = d; guard = 0; done = 1'b0; saw_req = 1'b0;
      start_cyc = cyc;
      l_req = 1'b1; err = eval_err; re_ack = 1'b0; r_ack = 1'b0;
      while (!done && guard < 200) begin
         step();
         guard++;
         if (abort && go_lm) begin
            #2;
            rst = 1'b0;
            #1;
            check_reset_outs("reset_mid_resolve");
            return;
         end
         if (l_ack) l_req = 1'b0;
         if (go_lm) begin
            k++;
            if (k <= gap) begin
               re_ack = 1'b0; err = 2'b01;
            end else if (k <= gap + n_fail) begin
               re_ack = 1'b1; err = fail_code;
            end else begin
               re_ack = 1'b1; err = 2'b00;
            end
         end else if (k > 0) begin
            re_ack = 1'b0; err = 2'b00;
         end
         if (r_req) begin
            saw_req = 1'b1;
            if (rdel == 0) r_ack = 1'b1;
            else rdel--;
         end else if (r_ack) begin
            r_ack = 1'b0;
         end
         done = exp_fault ? (fault === 1'b1) : (saw_req && !r_req && !r_ack && !l_ack && !l_req);
      end
      check("token_done", {31'd0, done}, 32'd1);
      repeat (exp_fault ? 5 : 2) step();
      check("capture_latency", first_pulse - start_cyc, 1);
      check("l_ack_after_pulse", lack_rise - first_pulse, 1);
      check("clk_en_pulses", pulses, exp_pulses);
      check("go_lm_cycles", lm_cyc, exp_lm);
      check("fault", {31'd0, fault}, {31'd0, exp_fault});
      check("invariants", viol, 0);
      check("err_count", {24'd0, err_count}, exp_cnt);
      if (exp_fault) check("r_req_in_fault", req_cyc, 0);
      else           check("r_req_cycles", req_cyc, d + 1);
   endtask

   initial begin
      logic [1:0] e0, fc;
      #12;
      check_reset_outs("reset_initial");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // IDLE must not capture while downstream still acknowledges.
      clear_stats();
      l_req = 1'b1; r_ack = 1'b1;
      repeat (3) step();
      check("idle_blocked_by_r_ack", pulses, 0);
      l_req = 1'b0; r_ack = 1'b0;
      step();

      token(2'b00, 0, 2'b00, 0, 1'b0);
      token(2'b01, 0, 2'b01, 1, 1'b0);
      token(2'b10, 2, 2'b01, 0, 1'b0);
      token(2'b10, 3, 2'b10, 0, 1'b0);
      check("fault_sticky", {31'd0, fault}, 32'd1);
      do_reset();
      token(2'b11, 0, 2'b00, 0, 1'b0);
      do_reset();

      // Reset while resolving: no pulse during or after, then a normal token.
      token(2'b01, 0, 2'b01, 5, 1'b1);
      l_req = 1'b0; r_ack = 1'b0; re_ack = 1'b0; err = 2'b00;
      clear_stats();
      repeat (2) step();
      rst = 1'b1; exp_cnt = 0;
      repeat (2) step();
      check("no_pulse_after_abort", pulses, 0);
      token(2'b00, 0, 2'b00, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         e0 = 2'($urandom_range(0, 3));
         fc = 2'($urandom_range(1, 3));
         token(e0, int'($urandom_range(0, 4)), fc, int'($urandom_range(0, 2)), 1'b0);
         if (fault) do_reset();
      end

      do_reset();
      for (int i = 0; i < 300; i++) token(2'b01, 0, 2'b01, 0, 1'b0);
      check("saturation", {24'd0, err_count}, CNT_EN ? 32'd255 : 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
